// File: rtl/pcs_tx_3b2t_mapper_pkg.sv
// Shared transmit/receive PCS definitions for the 3B2T ternary mapping.
// Contents:
//   T_NEG / T_ZERO / T_POS  - two's-complement ternary symbol encodings
//   SD_TAP_*                - scrambler state taps used to build Sd[2:0]
//   tx_state_t              - mapper control states
//   map_3b2t()              - 3B group to {TA, TB} lookup (also used by the rx demapper)
//   calc_sd()               - Sd[2:0] from the current side-stream LFSR state
package pcs_tx_3b2t_mapper_pkg;

    localparam logic [1:0] T_NEG  = 2'b11;
    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;

    localparam int SD_TAP_2  = 0;
    localparam int SD_TAP_1A = 3;
    localparam int SD_TAP_1B = 8;
    localparam int SD_TAP_0A = 6;
    localparam int SD_TAP_0B = 16;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } tx_state_t;

    // Returns {TA, TB}. The (0,0) pair is deliberately absent from the table.
    function automatic logic [3:0] map_3b2t(input logic [2:0] b3);
        logic [3:0] pair;
        case (b3)
            3'b000:  pair = {T_NEG,  T_NEG};
            3'b001:  pair = {T_NEG,  T_ZERO};
            3'b010:  pair = {T_NEG,  T_POS};
            3'b011:  pair = {T_ZERO, T_NEG};
            3'b100:  pair = {T_ZERO, T_POS};
            3'b101:  pair = {T_POS,  T_NEG};
            3'b110:  pair = {T_POS,  T_ZERO};
            default: pair = {T_POS,  T_POS};
        endcase
        return pair;
    endfunction

    function automatic logic [2:0] calc_sd(input logic [32:0] scr);
        return {scr[SD_TAP_2],
                scr[SD_TAP_1A] ^ scr[SD_TAP_1B],
                scr[SD_TAP_0A] ^ scr[SD_TAP_0B]};
    endfunction

endpackage

// File: rtl/tx_3b2t_lut.sv
// Combinational 3B to ternary pair map.
// Ports:
//   b3  in  3  scrambled 3-bit group
//   ta  out 2  first ternary symbol (two's complement)
//   tb  out 2  second ternary symbol (two's complement)
module tx_3b2t_lut
    import pcs_tx_3b2t_mapper_pkg::*;
(
    input  logic [2:0] b3,
    output logic [1:0] ta,
    output logic [1:0] tb
);

    always_comb begin
        {ta, tb} = map_3b2t(b3);
    end

endmodule

// File: rtl/pcs_tx_3b2t_mapper.sv
// Transmit PCS 3B2T mapper: scrambles 3-bit data groups (or sends scrambled
// idle) with Sd[2:0] from the side-stream LFSR and maps them onto ternary pairs.
// Ports:
//   clk           in   symbol clock
//   rst           in   synchronous active-high reset
//   tx_en         in   transmit enable
//   in_valid      in   data group present
//   in_data[2:0]  in   data group
//   in_ready      out  group accepted when in_valid & in_ready
//   scr_state[32:0] in current LFSR state
//   scr_adv       out  LFSR advance strobe
//   tx_ta/tx_tb   out  registered ternary pair
//   tx_sym_valid  out  pair valid
//   tx_is_data    out  pair carries data
//   scr_err       out  sticky all-zero LFSR flag
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_OFF    | LFSR held, no symbols, waiting for tx_en
// ST_WARMUP | idle pairs only, counting WARMUP_SYMS pairs
// ST_RUN    | data accepted every cycle, idle pairs fill the gaps
module pcs_tx_3b2t_mapper
    import pcs_tx_3b2t_mapper_pkg::*;
#(
    parameter int WARMUP_SYMS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        in_valid,
    input  logic [2:0]  in_data,
    output logic        in_ready,
    input  logic [32:0] scr_state,
    output logic        scr_adv,
    output logic [1:0]  tx_ta,
    output logic [1:0]  tx_tb,
    output logic        tx_sym_valid,
    output logic        tx_is_data,
    output logic        scr_err
);

    localparam logic [15:0] WU_LAST = 16'(WARMUP_SYMS - 1);

    tx_state_t   state, state_nxt;
    logic [15:0] wu_cnt;
    logic [2:0]  sd;
    logic [2:0]  b3;
    logic        data_sel;
    logic        emit;
    logic [1:0]  ta_nxt, tb_nxt;

    always_comb begin
        state_nxt = state;
        scr_adv   = 1'b0;
        in_ready  = 1'b0;
        case (state)
            ST_OFF: begin
                if (tx_en) state_nxt = ST_WARMUP;
            end
            ST_WARMUP: begin
                scr_adv = 1'b1;
                if (!tx_en)                 state_nxt = ST_OFF;
                else if (wu_cnt == WU_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                scr_adv  = 1'b1;
                in_ready = 1'b1;
                if (!tx_en) state_nxt = ST_OFF;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    always_comb begin
        sd       = calc_sd(scr_state);
        data_sel = in_ready & in_valid;
        b3       = data_sel ? (in_data ^ sd) : sd;
        emit     = (state != ST_OFF);
    end

    tx_3b2t_lut u_lut (
        .b3 (b3),
        .ta (ta_nxt),
        .tb (tb_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_OFF;
            wu_cnt       <= '0;
            tx_ta        <= T_ZERO;
            tx_tb        <= T_ZERO;
            tx_sym_valid <= 1'b0;
            tx_is_data   <= 1'b0;
            scr_err      <= 1'b0;
        end else begin
            state <= state_nxt;
            // Held at zero while off so every entry into warm-up starts fresh.
            if (state == ST_OFF)         wu_cnt <= '0;
            else if (state == ST_WARMUP) wu_cnt <= wu_cnt + 16'd1;
            tx_sym_valid <= emit;
            tx_ta        <= emit ? ta_nxt : T_ZERO;
            tx_tb        <= emit ? tb_nxt : T_ZERO;
            tx_is_data   <= data_sel;
            scr_err      <= scr_err | (emit && (scr_state == '0));
        end
    end

endmodule

// File: tb/tb_pcs_tx_3b2t_mapper.sv
module tb_pcs_tx_3b2t_mapper;

    localparam int WU = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic        in_valid;
    logic [2:0]  in_data;
    logic        in_ready;
    logic [32:0] scr_state;
    logic        scr_adv;
    logic [1:0]  tx_ta;
    logic [1:0]  tx_tb;
    logic        tx_sym_valid;
    logic        tx_is_data;
    logic        scr_err;

    always #5 clk = ~clk;

    pcs_tx_3b2t_mapper #(.WARMUP_SYMS(WU)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_en        (tx_en),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .scr_state    (scr_state),
        .scr_adv      (scr_adv),
        .tx_ta        (tx_ta),
        .tx_tb        (tx_tb),
        .tx_sym_valid (tx_sym_valid),
        .tx_is_data   (tx_is_data),
        .scr_err      (scr_err)
    );

    typedef struct packed {
        logic [1:0] ta;
        logic [1:0] tb;
        logic       is_data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] lfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Hand-written copy of the 3B2T table: {TA, TB}, -1=11, 0=00, +1=01
    function automatic logic [3:0] ref_map(input logic [2:0] b);
        case (b)
            3'b000:  return 4'b11_11;
            3'b001:  return 4'b11_00;
            3'b010:  return 4'b11_01;
            3'b011:  return 4'b00_11;
            3'b100:  return 4'b00_01;
            3'b101:  return 4'b01_11;
            3'b110:  return 4'b01_00;
            default: return 4'b01_01;
        endcase
    endfunction

    function automatic logic [2:0] ref_sd(input logic [32:0] s);
        return {s[0], s[3] ^ s[8], s[6] ^ s[16]};
    endfunction

    function automatic logic [32:0] lfsr_step(input logic [32:0] s);
        return {s[31:0], s[32] ^ s[12]};
    endfunction

    task automatic push_pair(input logic [2:0] b, input logic d);
        logic [3:0] p;
        exp_t       e;
        p = ref_map(b);
        e.ta = p[3:2];
        e.tb = p[1:0];
        e.is_data = d;
        exp_q.push_back(e);
    endtask

    task automatic off_cycle(input logic en, input logic chk_valid_low);
        @(negedge clk);
        tx_en = en; in_valid = 1'b0; in_data = 3'b000; scr_state = lfsr;
        #1;
        chk("off_adv", scr_adv, 0);
        chk("off_ready", in_ready, 0);
        if (chk_valid_low) chk("off_sym_valid", tx_sym_valid, 0);
    endtask

    task automatic warm_cycle();
        @(negedge clk);
        tx_en = 1'b1; in_valid = 1'b1; in_data = 3'b111; scr_state = lfsr;
        #1;
        chk("warm_adv", scr_adv, 1);
        chk("warm_ready", in_ready, 0);
        push_pair(ref_sd(lfsr), 1'b0);
        lfsr = lfsr_step(lfsr);
    endtask

    task automatic run_cycle(input logic en, input logic v, input logic [2:0] d);
        @(negedge clk);
        tx_en = en; in_valid = v; in_data = d; scr_state = lfsr;
        #1;
        chk("run_adv", scr_adv, 1);
        chk("run_ready", in_ready, 1);
        push_pair(v ? (d ^ ref_sd(lfsr)) : ref_sd(lfsr), v);
        lfsr = lfsr_step(lfsr);
    endtask

    // Monitor: pops one expected pair for every valid pair the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_sym_valid === 1'b1) begin
                chk("no_zero_pair", {30'd0, tx_ta, tx_tb} == 32'd0, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pair: got ta=%0h tb=%0h with nothing expected (t=%0t)",
                             tx_ta, tx_tb, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair", {tx_ta, tx_tb, tx_is_data}, {e.ta, e.tb, e.is_data});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tx_en = 1'b1; in_valid = 1'b0; in_data = 3'b000;
        lfsr = 33'h1; scr_state = lfsr;

        // Reset held three cycles with tx_en high
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_outputs", {tx_ta, tx_tb, tx_sym_valid, tx_is_data, scr_err}, 0);
            chk("rst_adv", scr_adv, 0);
            chk("rst_ready", in_ready, 0);
        end
        rst = 1'b0;   // still in the third cycle: OFF with tx_en=1 -> WARMUP at next edge

        repeat (WU) warm_cycle();

        run_cycle(1'b1, 1'b1, 3'b011);

        // Directed data pair: Sd from 33'h1_0000_0009 is 3'b110, 101^110=011 -> (0,-1)
        @(negedge clk);
        tx_en = 1'b1; in_valid = 1'b1; in_data = 3'b101; scr_state = 33'h1_0000_0009;
        #1;
        chk("dp_ready", in_ready, 1);
        exp_q.push_back('{ta: 2'b00, tb: 2'b11, is_data: 1'b1});
        lfsr = lfsr_step(lfsr);

        // Idle gap
        run_cycle(1'b1, 1'b1, 3'b010);
        run_cycle(1'b1, 1'b0, 3'b000);
        run_cycle(1'b1, 1'b1, 3'b110);
        chk("err_clear_before_lockup", scr_err, 0);

        // Disable mid-RUN: last group still accepted and output
        run_cycle(1'b0, 1'b1, 3'b100);
        off_cycle(1'b0, 1'b0);
        off_cycle(1'b0, 1'b1);

        // Re-enable: full warm-up again
        off_cycle(1'b1, 1'b1);
        repeat (WU) warm_cycle();
        run_cycle(1'b1, 1'b1, 3'b001);
        run_cycle(1'b1, 1'b0, 3'b000);

        // Lock-up: all-zero LFSR for one RUN cycle, idle -> Sd=000 -> (-1,-1)
        @(negedge clk);
        tx_en = 1'b1; in_valid = 1'b0; in_data = 3'b000; scr_state = 33'h0;
        #1;
        exp_q.push_back('{ta: 2'b11, tb: 2'b11, is_data: 1'b0});
        lfsr = lfsr_step(lfsr);
        run_cycle(1'b1, 1'b1, 3'b111);
        chk("scr_err_set", scr_err, 1);
        run_cycle(1'b1, 1'b0, 3'b000);
        run_cycle(1'b1, 1'b1, 3'b000);
        chk("scr_err_sticky", scr_err, 1);

        // Reset mid-RUN with a group offered: group dropped, outputs cleared
        @(negedge clk);
        rst = 1'b1; tx_en = 1'b1; in_valid = 1'b1; in_data = 3'b101; scr_state = lfsr;
        @(negedge clk);
        #1;
        chk("midrst_outputs", {tx_ta, tx_tb, tx_sym_valid, tx_is_data, scr_err}, 0);
        chk("midrst_adv", scr_adv, 0);
        chk("midrst_ready", in_ready, 0);
        rst = 1'b0; tx_en = 1'b0; in_valid = 1'b0;
        lfsr = 33'h1;

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
